// File: rtl/obs_pkg.sv
// Shared constants, state encoding and helpers for the 142-bit OBS
// partial-product stage.
package obs_pkg;

    localparam int N_142 = 142;  // operand width
    localparam int H_71  = 71;   // half width (even / odd coefficient halves)
    localparam int P_141 = 141;  // width of one 71x71 carry-less product

    // Digit counter width: wide enough to index 71 digits at D = 1.
    localparam int C_W = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Number of D-bit digits needed to cover an h-bit operand.
    function automatic int k_digits(input int h, input int d);
        return (h + d - 1) / d;
    endfunction

    // Even-indexed coefficients: result[i] = v[2i].
    function automatic logic [H_71-1:0] split_even(input logic [N_142-1:0] v);
        logic [H_71-1:0] r;
        for (int i = 0; i < H_71; i++) begin
            r[i] = v[2*i];
        end
        return r;
    endfunction

    // Odd-indexed coefficients: result[i] = v[2i+1].
    function automatic logic [H_71-1:0] split_odd(input logic [N_142-1:0] v);
        logic [H_71-1:0] r;
        for (int i = 0; i < H_71; i++) begin
            r[i] = v[2*i+1];
        end
        return r;
    endfunction

endpackage

// File: rtl/clmul_digit_step_71bit.sv
// One digit step of the serial carry-less multiplier:
// o_partial = (i_a * i_digit) << (i_c * D), all arithmetic over GF(2).
module clmul_digit_step_71bit
    import obs_pkg::*;
#(
    parameter int D = 8
) (
    input  logic [H_71-1:0]  i_a,
    input  logic [D-1:0]     i_digit,
    input  logic [C_W-1:0]   i_c,
    output logic [P_141-1:0] o_partial
);

    logic [P_141-1:0] w_prod;

    // Carry-less a x digit, then align the result to digit position c.
    // Bits pushed past bit 140 only ever come from the zero-padded top
    // digit, so truncating to the product width loses nothing.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        w_prod = '0;
        for (int j = 0; j < D; j++) begin
            if (i_digit[j]) begin
                w_prod = w_prod ^ (P_141'(i_a) << j);
            end
        end
        o_partial = w_prod << (int'(i_c) * D);
    end

endmodule

// File: rtl/obs_partial_product_seq_142bit.sv
// Sequential partial-product stage: splits A and B into even/odd halves and
// computes ae*be, ae*bo, ao*be, ao*bo one after another on a single shared
// digit-serial carry-less multiplier, then presents all four together.
module obs_partial_product_seq_142bit
    import obs_pkg::*;
#(
    parameter int D = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_142-1:0] A_in,
    input  logic [N_142-1:0] B_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P_141-1:0] B2_in1,
    output logic [P_141-1:0] B2_in2,
    output logic [P_141-1:0] B2_in3,
    output logic [P_141-1:0] B2_in4
);

    localparam int K  = k_digits(H_71, D);
    localparam int KD = K * D;
    localparam logic [C_W-1:0] C_LAST = C_W'(K - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_in_ready;
    logic             w_accept;
    logic             w_last_digit;

    logic [H_71-1:0]  r_ae;
    logic [H_71-1:0]  r_ao;
    logic [H_71-1:0]  r_be;
    logic [H_71-1:0]  r_bo;
    logic [P_141-1:0] r_acc;
    logic [1:0]       r_p;
    logic [C_W-1:0]   r_c;
    logic [P_141-1:0] r_prod [4];

    logic [H_71-1:0]  w_a_sel;
    logic [H_71-1:0]  w_b_sel;
    logic [KD-1:0]    w_b_pad;
    logic [D-1:0]     w_digit;
    logic [P_141-1:0] w_partial;
    logic [P_141-1:0] w_acc_next;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_next_state;
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last_digit = 1'b0;
        case (r_state)
            IDLE: begin
                // Accept only once in_ready is actually visible outside.
                if (r_in_ready && in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_c == C_LAST) begin
                    w_last_digit = 1'b1;
                    if (r_p == 2'd3) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // in_ready is registered so it stays low throughout reset and rises
    // the cycle after release, and the cycle after the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_next_state == IDLE);
        end
    end

    // Operand selection by product index: bit 1 picks the A half,
    // bit 0 picks the B half (0: ae*be, 1: ae*bo, 2: ao*be, 3: ao*bo).
    always_comb begin
        w_a_sel = r_p[1] ? r_ao : r_ae;
        w_b_sel = r_p[0] ? r_bo : r_be;
        // Zero-pad the top digit when D does not divide 71.
        w_b_pad              = '0;
        w_b_pad[H_71-1:0]    = w_b_sel;
        w_digit              = w_b_pad[int'(r_c) * D +: D];
    end

    clmul_digit_step_71bit #(
        .D (D)
    ) u_step (
        .i_a       (w_a_sel),
        .i_digit   (w_digit),
        .i_c       (r_c),
        .o_partial (w_partial)
    );

    assign w_acc_next = r_acc ^ w_partial;

    // Datapath: operand capture, digit accumulation, product write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ae  <= '0;
            r_ao  <= '0;
            r_be  <= '0;
            r_bo  <= '0;
            r_acc <= '0;
            r_p   <= '0;
            r_c   <= '0;
            // NOTE: the product registers feed the outputs directly and must
            // read zero out of reset, so this small array is reset in full.
            for (int i = 0; i < 4; i++) begin
                r_prod[i] <= '0;
            end
        end else if (w_accept) begin
            r_ae  <= split_even(A_in);
            r_ao  <= split_odd(A_in);
            r_be  <= split_even(B_in);
            r_bo  <= split_odd(B_in);
            r_acc <= '0;
            r_p   <= '0;
            r_c   <= '0;
        end else if (r_state == COMPUTE) begin
            if (w_last_digit) begin
                r_prod[r_p] <= w_acc_next;
                r_acc       <= '0;
                r_c         <= '0;
                r_p         <= r_p + 2'd1;
            end else begin
                r_acc <= w_acc_next;
                r_c   <= r_c + C_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == DONE);
    assign B2_in1    = r_prod[0];
    assign B2_in2    = r_prod[1];
    assign B2_in3    = r_prod[2];
    assign B2_in4    = r_prod[3];

endmodule
